// File: rtl/clause_event_arbiter.sv
// clause_event_arbiter
// Serialises the clause array's terminal flags into an event stream for the
// BCP / conflict-analysis engine. Each round takes a snapshot of the flags.
// The lowest-index conflict is reported and ends the round. With no conflict,
// implications drain in round-robin order, then a done pulse closes the round.
module clause_event_arbiter #(
    parameter int NUM_C     = 8,
    parameter int WIDTH_CID = 3,
    parameter int WIDTH_LVL = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic                       abort_i,
    input  logic [NUM_C-1:0]           csat_i,
    input  logic [NUM_C-1:0]           imp_i,
    input  logic [NUM_C-1:0]           conflict_i,
    input  logic [NUM_C*WIDTH_LVL-1:0] cmax_lvl_i,
    output logic                       evt_valid_o,
    input  logic                       evt_ready_i,
    output logic                       evt_is_conflict_o,
    output logic [WIDTH_CID-1:0]       evt_cid_o,
    output logic [WIDTH_LVL-1:0]       evt_lvl_o,
    output logic                       done_o,
    output logic                       all_sat_o,
    output logic [WIDTH_CID:0]         imp_cnt_o,
    output logic                       busy_o
);

    typedef enum logic [1:0] {IDLE, ARB, SEND, DONE} state_t;

    state_t                     state, state_n;
    logic [NUM_C-1:0]           conf_pend, conf_pend_n;
    logic [NUM_C-1:0]           imp_pend, imp_pend_n;
    logic [NUM_C*WIDTH_LVL-1:0] lvl_snap, lvl_snap_n;
    logic                       sat_snap, sat_snap_n;
    logic [WIDTH_CID:0]         imp_cnt, imp_cnt_n;
    logic [WIDTH_CID-1:0]       rr_ptr, rr_ptr_n;

    logic                       evt_valid_n, evt_is_conflict_n;
    logic [WIDTH_CID-1:0]       evt_cid_n;
    logic [WIDTH_LVL-1:0]       evt_lvl_n;
    logic                       done_n, all_sat_n, busy_n;
    logic [WIDTH_CID:0]         imp_cnt_out_n;
    logic [WIDTH_CID-1:0]       pick;

    // Lowest set index of a mask (conflicts are reported in index order).
    function automatic logic [WIDTH_CID-1:0] pick_lowest(input logic [NUM_C-1:0] m);
        logic [WIDTH_CID-1:0] r;
        r = '0;
        for (int i = NUM_C - 1; i >= 0; i--) begin
            if (m[i]) r = WIDTH_CID'(i);
        end
        return r;
    endfunction

    // First set index scanning from ptr upward, wrapping at NUM_C-1 -> 0.
    // The mask is rotated so ptr lands at bit 0, then the offset is added back.
    function automatic logic [WIDTH_CID-1:0] pick_rr(input logic [NUM_C-1:0] m,
                                                     input logic [WIDTH_CID-1:0] ptr);
        logic [2*NUM_C-1:0] dbl;
        logic [NUM_C-1:0]   rot;
        logic [WIDTH_CID:0] ptr_x, off, sum;
        dbl   = {m, m};
        ptr_x = {1'b0, ptr};
        rot   = dbl[ptr_x +: NUM_C];
        off   = '0;
        for (int i = NUM_C - 1; i >= 0; i--) begin
            if (rot[i]) off = (WIDTH_CID+1)'(i);
        end
        sum = ptr_x + off;
        if (sum >= (WIDTH_CID+1)'(NUM_C)) sum = sum - (WIDTH_CID+1)'(NUM_C);
        return sum[WIDTH_CID-1:0];
    endfunction

    // Captured max level of one clause.
    function automatic logic [WIDTH_LVL-1:0] lvl_of(input logic [NUM_C*WIDTH_LVL-1:0] snap,
                                                    input logic [WIDTH_CID-1:0] cid);
        logic [WIDTH_LVL-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_C; i++) begin
            if (cid == WIDTH_CID'(i)) r = snap[i*WIDTH_LVL +: WIDTH_LVL];
        end
        return r;
    endfunction

    // Implication counter never exceeds NUM_C.
    function automatic logic [WIDTH_CID:0] sat_inc(input logic [WIDTH_CID:0] c);
        if (c == (WIDTH_CID+1)'(NUM_C)) return c;
        return c + 1'b1;
    endfunction

    // Round-robin successor of the clause just delivered.
    function automatic logic [WIDTH_CID-1:0] rr_next(input logic [WIDTH_CID-1:0] cid);
        if (cid == WIDTH_CID'(NUM_C - 1)) return '0;
        return cid + 1'b1;
    endfunction

    // Next-state, next snapshot and next registered outputs; abort overrides all.
    always_comb begin
        state_n           = state;
        conf_pend_n       = conf_pend;
        imp_pend_n        = imp_pend;
        lvl_snap_n        = lvl_snap;
        sat_snap_n        = sat_snap;
        imp_cnt_n         = imp_cnt;
        rr_ptr_n          = rr_ptr;
        evt_valid_n       = evt_valid_o;
        evt_is_conflict_n = evt_is_conflict_o;
        evt_cid_n         = evt_cid_o;
        evt_lvl_n         = evt_lvl_o;
        done_n            = 1'b0;
        all_sat_n         = 1'b0;
        imp_cnt_out_n     = '0;
        pick              = '0;

        if (abort_i) begin
            state_n     = IDLE;
            evt_valid_n = 1'b0;
            conf_pend_n = '0;
            imp_pend_n  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        conf_pend_n = conflict_i;
                        imp_pend_n  = imp_i & ~csat_i & ~conflict_i;
                        lvl_snap_n  = cmax_lvl_i;
                        sat_snap_n  = &csat_i;
                        imp_cnt_n   = '0;
                        state_n     = ARB;
                    end
                end
                ARB: begin
                    if (|conf_pend) begin
                        pick              = pick_lowest(conf_pend);
                        evt_is_conflict_n = 1'b1;
                        evt_cid_n         = pick;
                        evt_lvl_n         = lvl_of(lvl_snap, pick);
                        evt_valid_n       = 1'b1;
                        state_n           = SEND;
                    end else if (|imp_pend) begin
                        pick              = pick_rr(imp_pend, rr_ptr);
                        evt_is_conflict_n = 1'b0;
                        evt_cid_n         = pick;
                        evt_lvl_n         = lvl_of(lvl_snap, pick);
                        evt_valid_n       = 1'b1;
                        state_n           = SEND;
                    end else begin
                        done_n        = 1'b1;
                        all_sat_n     = sat_snap;
                        imp_cnt_out_n = imp_cnt;
                        state_n       = DONE;
                    end
                end
                SEND: begin
                    if (evt_ready_i) begin
                        evt_valid_n = 1'b0;
                        if (evt_is_conflict_o) begin
                            conf_pend_n   = '0;
                            imp_pend_n    = '0;
                            done_n        = 1'b1;
                            all_sat_n     = sat_snap;
                            imp_cnt_out_n = imp_cnt;
                            state_n       = DONE;
                        end else begin
                            imp_pend_n = imp_pend & ~(NUM_C'(1) << evt_cid_o);
                            imp_cnt_n  = sat_inc(imp_cnt);
                            rr_ptr_n   = rr_next(evt_cid_o);
                            state_n    = ARB;
                        end
                    end
                end
                DONE: begin
                    state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
        busy_n = (state_n != IDLE);
    end

    // State, snapshot and output registers; everything clears on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            conf_pend         <= '0;
            imp_pend          <= '0;
            lvl_snap          <= '0;
            sat_snap          <= 1'b0;
            imp_cnt           <= '0;
            rr_ptr            <= '0;
            evt_valid_o       <= 1'b0;
            evt_is_conflict_o <= 1'b0;
            evt_cid_o         <= '0;
            evt_lvl_o         <= '0;
            done_o            <= 1'b0;
            all_sat_o         <= 1'b0;
            imp_cnt_o         <= '0;
            busy_o            <= 1'b0;
        end else begin
            state             <= state_n;
            conf_pend         <= conf_pend_n;
            imp_pend          <= imp_pend_n;
            lvl_snap          <= lvl_snap_n;
            sat_snap          <= sat_snap_n;
            imp_cnt           <= imp_cnt_n;
            rr_ptr            <= rr_ptr_n;
            evt_valid_o       <= evt_valid_n;
            evt_is_conflict_o <= evt_is_conflict_n;
            evt_cid_o         <= evt_cid_n;
            evt_lvl_o         <= evt_lvl_n;
            done_o            <= done_n;
            all_sat_o         <= all_sat_n;
            imp_cnt_o         <= imp_cnt_out_n;
            busy_o            <= busy_n;
        end
    end

endmodule

// File: doc/clause_event_arbiter.md
Name: clause_event_arbiter

Overview:
- Sequences the per-clause terminal outputs of the clause array (implication drive, conflict drive, satisfied flag, max decision level) into a serial event stream for the BCP / conflict-analysis engine.
- On each propagation round it snapshots all clause flags.
- Conflicts win over implications: the lowest-index conflicting clause is reported and the round ends.
- Otherwise implying clauses are drained one at a time in round-robin order, followed by a round-complete pulse carrying the all-satisfied status.

Parameters:
- NUM_C, 8, number of clauses in the array (≥2)
- WIDTH_CID, 3, clause id width, equals clog2(NUM_C)
- WIDTH_LVL, 16, decision level width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- start_i  in  1  one-cycle pulse, clause array settled, begin round
- abort_i  in  1  flush round (backtrack)
- csat_i  in  NUM_C  per-clause satisfied
- imp_i  in  NUM_C  per-clause implication drive (one free literal)
- conflict_i  in  NUM_C  per-clause conflict drive
- cmax_lvl_i  in  NUM_C*WIDTH_LVL  per-clause max level, clause c at bits [c*WIDTH_LVL +: WIDTH_LVL]
- evt_valid_o  out  1  event available
- evt_ready_i  in  1  consumer accepts event
- evt_is_conflict_o  out  1  1 = conflict event, 0 = implication
- evt_cid_o  out  WIDTH_CID  clause id of event
- evt_lvl_o  out  WIDTH_LVL  captured cmax_lvl of that clause
- done_o  out  1  one-cycle round-complete pulse
- all_sat_o  out  1  valid with done_o, all clauses satisfied at snapshot
- imp_cnt_o  out  WIDTH_CID+1  implications delivered this round, valid with done_o
- busy_o  out  1  state != IDLE

Behaviour:
- Async reset (rst=0):
  - state IDLE; all outputs 0.
  - rr_ptr=0, pending masks 0, level snapshot 0.
- FSM states: IDLE, ARB, SEND, DONE.
- IDLE:
  - start_i=1 at edge k causes the following snapshot:
    - conf_pend=conflict_i
    - imp_pend=imp_i & ~csat_i & ~conflict_i
    - lvl_snap=cmax_lvl_i
    - sat_snap=&csat_i
    - imp_cnt=0
  - Next state ARB.
  - start_i in any other state is ignored.
- ARB (combinational pick, outputs registered at edge):
  - conf_pend≠0: pick lowest set index; evt_is_conflict_o=1; go to SEND.
  - else imp_pend≠0: pick first set index scanning rr_ptr, rr_ptr+1, … wrapping at NUM_C-1→0; evt_is_conflict_o=0; go to SEND.
  - else: go to DONE.
  - evt_cid_o / evt_lvl_o loaded from the pick and lvl_snap.
- SEND:
  - evt_valid_o=1; all evt_* outputs held stable until the handshake.
  - Handshake is evt_valid_o & evt_ready_i at an edge. On handshake, evt_valid_o drops next cycle.
    - Conflict event: clear conf_pend and imp_pend; go to DONE. Remaining implications are discarded.
    - Implication event: clear that imp_pend bit; imp_cnt+=1; rr_ptr=(cid+1) mod NUM_C; go to ARB.
  - Minimum spacing between events is 2 cycles.
  - First evt_valid_o is high in cycle k+2 after start at edge k.
- DONE:
  - done_o=1 for exactly one cycle.
  - all_sat_o=sat_snap and imp_cnt_o=imp_cnt, both valid only while done_o=1, 0 otherwise.
  - Next state IDLE.
- Empty round (no conflict, no implication): done_o at cycle k+2.
- abort_i:
  - Highest priority; checked in every state.
  - Next edge goes to IDLE, evt_valid_o=0, pending masks cleared, no done_o.
  - rr_ptr retained.
  - abort_i together with start_i in IDLE: abort wins, round not started.
- Snapshot semantics: input changes after capture do not affect the round.
- imp_cnt saturates at NUM_C (cannot exceed by construction).
- rr_ptr wraps modulo NUM_C; for non-power-of-two NUM_C, NUM_C-1 wraps to 0.
- Outputs are all registered; no combinational path from inputs to outputs.

Test Plan:
- Reset mid-SEND (rst low with evt_valid_o=1) -> all outputs 0 immediately, rr_ptr=0; next start_i behaves as a fresh round.
- NUM_C=8, imp_i=8'b1001_0010, csat_i=0, conflict_i=0, rr_ptr=0, evt_ready_i=1 -> events cid 1,4,7 (conflict=0) at cycles k+2,k+4,k+6, then done_o with imp_cnt_o=3, all_sat_o=0, rr_ptr=0.
- conflict_i=8'b0010_1000, imp_i=8'b0000_0011, cmax_lvl of c3=5 -> single event cid=3, evt_is_conflict_o=1, evt_lvl_o=5, then done_o, imp_cnt_o=0; no implication events.
- csat_i=8'hFF, imp_i=0, conflict_i=0 -> no evt_valid_o, done_o at k+2, all_sat_o=1; imp_i bit set with csat bit also set -> masked, no event.
- Backpressure and abort:
  - evt_ready_i low for 5 cycles in SEND -> evt_* stable, then accepted.
  - abort_i during SEND -> evt_valid_o=0 next cycle, IDLE, no done_o.
  - Next round with imp_i=8'b0000_0101, rr_ptr=2 -> order cid 2,0.
